// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter giving two requesters access to one shared
// combinational ALU, one operation at a time (grant -> execute -> respond).
`default_nettype none

module alu_arbiter #(
    parameter int W         = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0,
    input  logic [2:0]   ctrl0,
    input  logic [4:0]   num0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    output logic         gnt0,
    output logic         rvalid0,
    output logic [W-1:0] rdata0,
    input  logic         rready0,

    input  logic         req1,
    input  logic [2:0]   ctrl1,
    input  logic [4:0]   num1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt1,
    output logic         rvalid1,
    output logic [W-1:0] rdata1,
    input  logic         rready1,

    output logic [2:0]   alu_ctrl,
    output logic [4:0]   alu_num,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_y,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ptr;
    logic           owner;
    logic [2:0]     op_ctrl;
    logic [4:0]     op_num;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   result;

    logic           grant;
    logic           sel;
    logic           owner_ready;

    assign owner_ready = owner ? rready1 : rready0;

    // sel: pointed-to requester if it is asking, otherwise the other one
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        sel       = ptr ? req1 : ~req0;
        case (state)
            IDLE: begin
                if (rst_n && (req0 || req1)) begin
                    grant     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt0 = grant & ~sel;
    assign gnt1 = grant &  sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PRIO_INIT;
            owner   <= 1'b0;
            op_ctrl <= '0;
            op_num  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner   <= sel;
                op_ctrl <= sel ? ctrl1 : ctrl0;
                op_num  <= sel ? num1  : num0;
                op_a    <= sel ? a1    : a0;
                op_b    <= sel ? b1    : b0;
            end
            if (state == EXEC) begin
                result <= alu_y;
            end
            if (state == RESP && owner_ready) begin
                ptr <= ~owner;
            end
        end
    end

    assign rvalid0  = (state == RESP) && !owner;
    assign rvalid1  = (state == RESP) &&  owner;
    assign rdata0   = rvalid0 ? result : '0;
    assign rdata1   = rvalid1 ? result : '0;

    assign alu_ctrl = op_ctrl;
    assign alu_num  = op_num;
    assign alu_a    = op_a;
    assign alu_b    = op_b;

    assign busy     = (state != IDLE);

endmodule

`default_nettype wire
